// File: rtl/thumb_fmt_pkg.sv
// Shared definitions for the Thumb decode queue.
// Holds the Thumb format codes (1..19, 0 = invalid), the BL half-word opcodes,
// the BL fusion FSM states and the packed layout of one queue entry.
package thumb_fmt_pkg;

  localparam logic [4:0] FMT_INVALID      = 5'd0;
  localparam logic [4:0] FMT_MOVE_SHIFTED = 5'd1;
  localparam logic [4:0] FMT_ADD_SUB      = 5'd2;
  localparam logic [4:0] FMT_IMM          = 5'd3;
  localparam logic [4:0] FMT_ALU          = 5'd4;
  localparam logic [4:0] FMT_HI_REG_BX    = 5'd5;
  localparam logic [4:0] FMT_PC_LOAD      = 5'd6;
  localparam logic [4:0] FMT_LS_REG       = 5'd7;
  localparam logic [4:0] FMT_LS_SIGN      = 5'd8;
  localparam logic [4:0] FMT_LS_IMM       = 5'd9;
  localparam logic [4:0] FMT_LS_HALF      = 5'd10;
  localparam logic [4:0] FMT_SP_LS        = 5'd11;
  localparam logic [4:0] FMT_LOAD_ADDR    = 5'd12;
  localparam logic [4:0] FMT_ADD_SP       = 5'd13;
  localparam logic [4:0] FMT_PUSH_POP     = 5'd14;
  localparam logic [4:0] FMT_MULTI_LS     = 5'd15;
  localparam logic [4:0] FMT_COND_BR      = 5'd16;
  localparam logic [4:0] FMT_SWI          = 5'd17;
  localparam logic [4:0] FMT_UNCOND_BR    = 5'd18;
  localparam logic [4:0] FMT_LONG_BL      = 5'd19;

  // insn[15:11] of the two BL halves
  localparam logic [4:0] BL_PREFIX = 5'b11110;
  localparam logic [4:0] BL_SUFFIX = 5'b11111;

  typedef enum logic {
    IDLE  = 1'b0,
    BL_HI = 1'b1
  } bl_state_e;

  typedef struct packed {
    logic [4:0]  sel;
    logic [15:0] insn;
    logic [10:0] prefix;
    logic        err;
  } q_entry_t;

endpackage

// File: rtl/thumb_fmt_decode.sv
// Combinational Thumb format classifier.
// Ports:
//   i_insn  [15:0] Thumb halfword
//   o_sel   [4:0]  format number 1..19, 0 when the encoding is not recognised
//   o_undef        high when o_sel is 0
module thumb_fmt_decode
  import thumb_fmt_pkg::*;
(
  input  logic [15:0] i_insn,
  output logic [4:0]  o_sel,
  output logic        o_undef
);

  logic [4:0] w_sel;

  // Ordered by priority: format 2 is carved out of the 000xx space,
  // and SWI (cond=1111) out of the conditional-branch space.
  always_comb begin
    w_sel = FMT_INVALID;
    if (i_insn[15:11] == 5'b00011)                                w_sel = FMT_ADD_SUB;
    else if (i_insn[15:13] == 3'b000)                             w_sel = FMT_MOVE_SHIFTED;
    else if (i_insn[15:13] == 3'b001)                             w_sel = FMT_IMM;
    else if (i_insn[15:10] == 6'b010000)                          w_sel = FMT_ALU;
    else if (i_insn[15:10] == 6'b010001)                          w_sel = FMT_HI_REG_BX;
    else if (i_insn[15:11] == 5'b01001)                           w_sel = FMT_PC_LOAD;
    else if (i_insn[15:12] == 4'b0101 && !i_insn[9])              w_sel = FMT_LS_REG;
    else if (i_insn[15:12] == 4'b0101 && i_insn[9])               w_sel = FMT_LS_SIGN;
    else if (i_insn[15:13] == 3'b011)                             w_sel = FMT_LS_IMM;
    else if (i_insn[15:12] == 4'b1000)                            w_sel = FMT_LS_HALF;
    else if (i_insn[15:12] == 4'b1001)                            w_sel = FMT_SP_LS;
    else if (i_insn[15:12] == 4'b1010)                            w_sel = FMT_LOAD_ADDR;
    else if (i_insn[15:8] == 8'b10110000)                         w_sel = FMT_ADD_SP;
    else if (i_insn[15:12] == 4'b1011 && i_insn[10:9] == 2'b10)   w_sel = FMT_PUSH_POP;
    else if (i_insn[15:12] == 4'b1100)                            w_sel = FMT_MULTI_LS;
    else if (i_insn[15:8] == 8'b11011111)                         w_sel = FMT_SWI;
    else if (i_insn[15:12] == 4'b1101)                            w_sel = FMT_COND_BR;
    else if (i_insn[15:11] == 5'b11100)                           w_sel = FMT_UNCOND_BR;
    else if (i_insn[15:12] == 4'b1111)                            w_sel = FMT_LONG_BL;
  end

  assign o_sel   = w_sel;
  assign o_undef = (w_sel == FMT_INVALID);

endmodule

// File: rtl/thumb_decode_queue.sv
// Decode-stage front end for the Thumb pipeline.
// Classifies incoming halfwords, optionally fuses BL prefix+suffix into one
// entry, and buffers the results in a DEPTH-entry FIFO feeding execute.
// Ports:
//   clk, rst (async, active-high), flush (sync, branch redirect)
//   in_valid/in_ready/in_insn          : instruction input handshake
//   out_valid/out_ready                : head entry handshake
//   out_sel/out_insn/out_prefix/out_err: head entry fields, zero when empty
module thumb_decode_queue
  import thumb_fmt_pkg::*;
#(
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FUSE_BL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [15:0]      out_insn,
  output logic [10:0]      out_prefix,
  output logic             out_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  q_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  bl_state_e   r_state;
  bl_state_e   w_state_nxt;
  logic        r_orphan;
  logic        w_orphan_nxt;
  logic [10:0] r_latch;
  logic [10:0] w_latch_nxt;

  logic [4:0]  w_dec_sel;
  logic        w_dec_undef;
  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  logic        w_is_prefix;
  logic        w_is_suffix;
  q_entry_t    w_entry;
  q_entry_t    w_head;

  thumb_fmt_decode u_fmt_decode (
    .i_insn  (in_insn),
    .o_sel   (w_dec_sel),
    .o_undef (w_dec_undef)
  );

  assign in_ready  = (r_count != FULL_CNT) && !flush;
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // With fusion disabled, BL halves fall through the ordinary decode path
  // and come out as plain format-19 entries.
  assign w_is_prefix = (FUSE_BL != 0) && (in_insn[15:11] == BL_PREFIX);
  assign w_is_suffix = (FUSE_BL != 0) && (in_insn[15:11] == BL_SUFFIX);

  always_comb begin
    w_state_nxt  = r_state;
    w_orphan_nxt = r_orphan;
    w_latch_nxt  = r_latch;
    w_push       = 1'b0;
    w_entry      = '{sel: w_dec_sel, insn: in_insn, prefix: 11'd0, err: w_dec_undef};

    if (w_accept) begin
      unique case (r_state)
        IDLE: begin
          if (w_is_prefix) begin
            w_latch_nxt = in_insn[10:0];
            w_state_nxt = BL_HI;
          end else if (w_is_suffix) begin
            w_push      = 1'b1;
            w_entry.sel = FMT_LONG_BL;
            w_entry.err = 1'b1;
          end else begin
            w_push       = 1'b1;
            w_entry.err  = r_orphan | w_dec_undef;
            w_orphan_nxt = 1'b0;
          end
        end
        BL_HI: begin
          if (w_is_suffix) begin
            w_push         = 1'b1;
            w_entry.sel    = FMT_LONG_BL;
            w_entry.prefix = r_latch;
            w_entry.err    = 1'b0;
            w_state_nxt    = IDLE;
          end else if (w_is_prefix) begin
            // A second prefix supersedes the first; the lost one is remembered.
            w_latch_nxt  = in_insn[10:0];
            w_orphan_nxt = 1'b1;
          end else begin
            // Dropped prefix is reported on this entry, so the flag is consumed here.
            w_push       = 1'b1;
            w_entry.err  = 1'b1;
            w_latch_nxt  = 11'd0;
            w_orphan_nxt = 1'b0;
            w_state_nxt  = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (flush) begin
      w_state_nxt  = IDLE;
      w_orphan_nxt = 1'b0;
      w_latch_nxt  = 11'd0;
      w_push       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_orphan <= 1'b0;
      r_latch  <= 11'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_orphan <= w_orphan_nxt;
      r_latch  <= w_latch_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
  end

  assign w_head     = r_mem[r_head];
  assign out_sel    = out_valid ? SEL_W'(w_head.sel) : '0;
  assign out_insn   = out_valid ? w_head.insn        : 16'd0;
  assign out_prefix = out_valid ? w_head.prefix      : 11'd0;
  assign out_err    = out_valid ? w_head.err         : 1'b0;

endmodule

// File: tb/tb_thumb_decode_queue.sv
module tb_thumb_decode_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_insn;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_sel;
  logic [15:0] out_insn;
  logic [10:0] out_prefix;
  logic        out_err;

  // Second instance with BL fusion disabled
  logic        n_flush;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [15:0] n_in_insn;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [5:0]  n_out_sel;
  logic [15:0] n_out_insn;
  logic [10:0] n_out_prefix;
  logic        n_out_err;

  always #5 clk = ~clk;

  thumb_decode_queue #(.SEL_W(6), .DEPTH(DEPTH), .FUSE_BL(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_insn    (in_insn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sel    (out_sel),
    .out_insn   (out_insn),
    .out_prefix (out_prefix),
    .out_err    (out_err)
  );

  thumb_decode_queue #(.SEL_W(6), .DEPTH(DEPTH), .FUSE_BL(0)) u_dut_nofuse (
    .clk        (clk),
    .rst        (rst),
    .flush      (n_flush),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .in_insn    (n_in_insn),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_sel    (n_out_sel),
    .out_insn   (n_out_insn),
    .out_prefix (n_out_prefix),
    .out_err    (n_out_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned sel;
    logic [15:0] insn;
    logic [10:0] pre;
    bit          err;
  } ent_t;

  ent_t        mq[$];
  bit          m_bl;
  bit          m_orph;
  logic [10:0] m_lat;

  function automatic int unsigned ref_fmt(input logic [15:0] insn);
    logic [7:0] hi;
    hi = insn[15:8];
    casez (hi)
      8'b00011???: return 2;
      8'b000?????: return 1;
      8'b001?????: return 3;
      8'b010000??: return 4;
      8'b010001??: return 5;
      8'b01001???: return 6;
      8'b0101??0?: return 7;
      8'b0101??1?: return 8;
      8'b011?????: return 9;
      8'b1000????: return 10;
      8'b1001????: return 11;
      8'b1010????: return 12;
      8'b10110000: return 13;
      8'b1011?10?: return 14;
      8'b1100????: return 15;
      8'b11011111: return 17;
      8'b1101????: return 16;
      8'b11100???: return 18;
      8'b1111????: return 19;
      default:     return 0;
    endcase
  endfunction

  task automatic m_push(input int unsigned sel, input logic [15:0] insn,
                        input logic [10:0] pre, input bit err);
    ent_t e;
    e.sel = sel; e.insn = insn; e.pre = pre; e.err = err;
    mq.push_back(e);
  endtask

  task automatic model_reset();
    mq.delete();
    m_bl = 0; m_orph = 0; m_lat = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    bit acc, pop, pre, suf;
    int unsigned f;
    acc = in_valid && (mq.size() != DEPTH) && !flush;
    pop = (mq.size() != 0) && out_ready;
    if (flush) begin
      model_reset();
      return;
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      pre = (in_insn[15:11] == 5'b11110);
      suf = (in_insn[15:11] == 5'b11111);
      f   = ref_fmt(in_insn);
      if (!m_bl) begin
        if (pre) begin
          m_lat = in_insn[10:0]; m_bl = 1;
        end else if (suf) begin
          m_push(19, in_insn, 11'd0, 1);
        end else begin
          m_push(f, in_insn, 11'd0, m_orph || (f == 0)); m_orph = 0;
        end
      end else if (suf) begin
        m_push(19, in_insn, m_lat, 0); m_bl = 0;
      end else if (pre) begin
        m_lat = in_insn[10:0]; m_orph = 1;
      end else begin
        m_push(f, in_insn, 11'd0, 1); m_orph = 0; m_bl = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() != DEPTH) && !flush});
    check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    if (mq.size() == 0) begin
      check("out_sel_empty", {26'd0, out_sel}, 32'd0);
      check("out_insn_empty", {16'd0, out_insn}, 32'd0);
      check("out_prefix_empty", {21'd0, out_prefix}, 32'd0);
      check("out_err_empty", {31'd0, out_err}, 32'd0);
    end else begin
      check("out_sel", {26'd0, out_sel}, mq[0].sel);
      check("out_insn", {16'd0, out_insn}, {16'd0, mq[0].insn});
      check("out_prefix", {21'd0, out_prefix}, {21'd0, mq[0].pre});
      check("out_err", {31'd0, out_err}, {31'd0, mq[0].err});
    end
  endtask

  // One cycle: drive inputs, check at negedge, clock the model, then idle inputs.
  task automatic step(input logic v, input logic [15:0] insn, input logic rdy, input logic fl);
    in_valid = v; in_insn = insn; out_ready = rdy; flush = fl;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_clock();
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic push_peek(input logic [15:0] insn, input int unsigned sel, input bit err,
                           input string tag);
    step(1'b1, insn, 1'b0, 1'b0);
    check({tag, "_sel"}, {26'd0, out_sel}, sel);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
    step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  logic [15:0] r_insn;
  int unsigned r_kind;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0; out_ready = 1'b0;
    n_flush = 1'b0; n_in_valid = 1'b0; n_in_insn = '0; n_out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sel", {26'd0, out_sel}, 32'd0);
    check("rst_out_insn", {16'd0, out_insn}, 32'd0);
    check("rst_out_prefix", {21'd0, out_prefix}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD imm3, latency one cycle
    push_peek(16'h1C08, 2, 0, "add_imm3");

    // Fused BL pair
    step(1'b1, 16'hF000, 1'b0, 1'b0);
    check("bl_prefix_no_push", {31'd0, out_valid}, 32'd0);
    step(1'b1, 16'hF800, 1'b0, 1'b0);
    check("bl_sel", {26'd0, out_sel}, 32'd19);
    check("bl_prefix", {21'd0, out_prefix}, 32'd0);
    check("bl_insn", {16'd0, out_insn}, 32'h0000F800);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Orphan prefix followed by a normal instruction, then a lone suffix
    step(1'b1, 16'hF123, 1'b0, 1'b0);
    push_peek(16'h2001, 3, 1, "orphan_prefix");
    push_peek(16'hF800, 19, 1, "orphan_suffix");

    // Fill to full, pop one, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h3000 | 16'(i), 1'b0, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 16'h3009, 1'b1, 1'b0);
    check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush with 3 entries queued and FSM in BL_HI
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h2002, 1'b0, 1'b0);
    step(1'b1, 16'h4003, 1'b0, 1'b0);
    step(1'b1, 16'hF555, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    push_peek(16'hF800, 19, 1, "flush_suffix");

    // Boundary encodings
    push_peek(16'hDF05, 17, 0, "swi");
    push_peek(16'hDE00, 16, 0, "cond_br");
    push_peek(16'hE800, 0, 1, "undef");

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      r_kind = $urandom_range(0, 3);
      if (r_kind == 0)      r_insn = {5'b11110, 11'($urandom)};
      else if (r_kind == 1) r_insn = {5'b11111, 11'($urandom)};
      else                  r_insn = 16'($urandom);
      step($urandom_range(0, 9) < 7, r_insn, $urandom_range(0, 1) == 1,
           $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset mid-operation, with the FSM holding a prefix
    step(1'b1, 16'h4000, 1'b0, 1'b0);
    step(1'b1, 16'h2abc, 1'b0, 1'b0);
    step(1'b1, 16'hF321, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_sel", {26'd0, out_sel}, 32'd0);
    check("arst_out_insn", {16'd0, out_insn}, 32'd0);
    check("arst_out_err", {31'd0, out_err}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    push_peek(16'hF800, 19, 1, "arst_suffix");

    // Fusion disabled: each BL half is its own clean format-19 entry
    n_in_valid = 1'b1; n_in_insn = 16'hF000; n_out_ready = 1'b0;
    @(posedge clk); #1;
    check("nofuse_in_ready", {31'd0, n_in_ready}, 32'd1);
    check("nofuse_pre_valid", {31'd0, n_out_valid}, 32'd1);
    check("nofuse_pre_sel", {26'd0, n_out_sel}, 32'd19);
    check("nofuse_pre_err", {31'd0, n_out_err}, 32'd0);
    check("nofuse_pre_insn", {16'd0, n_out_insn}, 32'h0000F000);
    n_in_insn = 16'hF800; n_out_ready = 1'b1;
    @(posedge clk); #1;
    check("nofuse_suf_sel", {26'd0, n_out_sel}, 32'd19);
    check("nofuse_suf_insn", {16'd0, n_out_insn}, 32'h0000F800);
    check("nofuse_suf_err", {31'd0, n_out_err}, 32'd0);
    check("nofuse_suf_prefix", {21'd0, n_out_prefix}, 32'd0);
    n_in_insn = 16'h2001;
    @(posedge clk); #1;
    check("nofuse_next_sel", {26'd0, n_out_sel}, 32'd3);
    check("nofuse_next_err", {31'd0, n_out_err}, 32'd0);
    n_in_valid = 1'b0;
    @(posedge clk); #1;
    check("nofuse_drained", {31'd0, n_out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
